// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin arbiter.
// Imported by rr_arbiter_8 and by anything that binds checkers to it.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder_3to8.sv
// Plain 3-to-8 one-hot decoder; output yN is high when sel == N.
module decoder_3to8 (
  input  logic [2:0] sel,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       y4,
  output logic       y5,
  output logic       y6,
  output logic       y7
);

  assign y0 = (sel == 3'd0);
  assign y1 = (sel == 3'd1);
  assign y2 = (sel == 3'd2);
  assign y3 = (sel == 3'd3);
  assign y4 = (sel == 3'd4);
  assign y5 = (sel == 3'd5);
  assign y6 = (sel == 3'd6);
  assign y7 = (sel == 3'd7);

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters: one owner at a time, held until done,
// request drop or MAX_HOLD cycles; at least one IDLE cycle between grants.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // Handshake: req[i] is a level request; the owner keeps gnt while req[i]
  // stays high and done is low. done is only honoured while gnt_valid=1.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             owner_req;
  logic             at_max;
  logic             release_now;
  logic [N_REQ-1:0] dec;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   first;
    dbl   = {r, r};
    rot   = dbl[p +: N_REQ];
    first = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = IDX_W'(i);
    end
    return first + p;
  endfunction

  assign pick        = rr_pick(req, ptr_q);
  assign any_req     = |req;
  assign owner_req   = req[idx_q];
  assign at_max      = (cnt_q == CNT_W'(MAX_HOLD));
  assign release_now = done | ~owner_req | at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = pick;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          // Only a pure hold-limit release is reported as a timeout.
          tmo_d   = at_max & ~done & owner_req;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  decoder_3to8 u_dec (
    .sel (idx_q),
    .y0  (dec[0]),
    .y1  (dec[1]),
    .y2  (dec[2]),
    .y3  (dec[3]),
    .y4  (dec[4]),
    .y5  (dec[5]),
    .y6  (dec[6]),
    .y7  (dec[7])
  );

  // gnt_valid is the FSM state bit itself, so it doubles as the state debug view.
  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign gnt       = dec & {N_REQ{gnt_valid}};
  assign timeout   = tmo_q;

endmodule
